seg7_mux_driver: RTL and testbench

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

---
 rtl/seg7_if.sv | 26 ++
 rtl/seg7_mux_driver.sv | 154 +++++++++++++++
 tb/tb_seg7_mux_driver.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// Bundle between a display controller (master) and seg7_mux_driver (slave):
// digit data, decimal points, enables, brightness and load strobe in;
// anodes, segments, decimal point and frame tick out.
interface seg7_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] input_bcd;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              brightness;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output input_bcd, dp_in, digit_en, brightness, load,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  input_bcd, dp_in, digit_en, brightness, load,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed 7-segment display driver.
// Each digit owns a slot of REFRESH_DIV cycles; the first GUARD_CYCLES of a
// slot keep every anode off, and brightness (sampled at slot start) sets how
// much of the remaining slot the anode stays on. Loaded data lands in a
// pending register and is committed to the display only at frame start, so a
// frame never mixes old and new digits.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 8
) (
  input logic   clk,
  input logic   rst_n,
  seg7_if.slave bus
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int LEN_W  = $clog2(REFRESH_DIV + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PROD_W = LEN_W + 5;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
  } frame_t;

  // Active-low hex glyphs, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  frame_t                pend_q, pend_d;
  frame_t                disp_q, disp_d;
  logic [LEN_W-1:0]      on_len_q, on_len_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  cnt_wrap;
  logic                  frame_start;
  logic [PROD_W-1:0]     duty_prod;
  logic [3:0]            nibble;
  logic                  lit;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                  upper_zero;
`endif

  assign cnt_wrap    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_start = (cnt_q == '0) && (idx_q == '0);
  // Full-width product so brightness 15 yields exactly REFRESH_DIV.
  assign duty_prod   = (PROD_W'(bus.brightness) + PROD_W'(1)) *
                       PROD_W'(REFRESH_DIV - GUARD_CYCLES);

  // Slot/digit counters, pending and display registers, per-slot on-length.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    pend_d   = pend_q;
    on_len_d = on_len_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (bus.load) begin
      pend_d = {bus.input_bcd, bus.dp_in, bus.digit_en};
    end
    // Taking pend_d (not pend_q) lets a load in the commit cycle show at once.
    disp_d = frame_start ? pend_d : disp_q;
    if (cnt_q == '0) begin
      on_len_d = LEN_W'(GUARD_CYCLES) + LEN_W'(duty_prod >> 4);
    end
  end

  // Next output values for the current slot position, registered below.
  always_comb begin
    nibble = disp_d.bcd[4*idx_q +: 4];
    lit    = (cnt_q >= CNT_W'(GUARD_CYCLES)) && (LEN_W'(cnt_q) < on_len_d) &&
             disp_d.en[idx_q];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    upper_zero = 1'b1;
    for (int j = 1; j < NUM_DIGITS; j++) begin
      if ((j > int'(idx_q)) && (disp_d.bcd[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    // Digit 0 always shows; a set decimal point keeps a zero digit visible.
    if ((idx_q != '0) && (nibble == 4'h0) && upper_zero && !disp_d.dp[idx_q]) begin
      lit = 1'b0;
    end
`endif
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_tick_d = frame_start;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = hex_to_seg(nibble);
      dp_d        = ~disp_d.dp[idx_q];
    end
  end

  // State and output registers; outputs change together on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, so the first frame after reset shows a known blank display.
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      on_len_q     <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      on_len_q     <= on_len_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Testbench for seg7_mux_driver (NUM_DIGITS=4, REFRESH_DIV=16, GUARD_CYCLES=2).
// The reference model tracks absolute time since reset release: frame
// position = edges mod 64, slot = position / 16, offset = position mod 16.
module tb_seg7_mux_driver;
  localparam int N     = 4;
  localparam int RD    = 16;
  localparam int G     = 2;
  localparam int FRAME = N * RD;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg7_if #(.NUM_DIGITS(N)) bus ();

  seg7_mux_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  int         k;
  logic [15:0] last_bcd, frame_bcd;
  logic [3:0]  last_dp, frame_dp, last_en, frame_en;
  int          slot_on;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ft;

  // One clock: update the model with the inputs seen at the edge, then move to
  // the falling edge where outputs are sampled and new inputs are driven.
  task automatic cycle();
    int p, d, c;
    logic blank, lit;
    logic [3:0] nib;
    @(posedge clk);
    if (rst_n) begin
      p = k % FRAME;
      d = p / RD;
      c = p % RD;
      k++;
      if (bus.load) begin
        last_bcd = bus.input_bcd;
        last_dp  = bus.dp_in;
        last_en  = bus.digit_en;
      end
      if (p == 0) begin
        frame_bcd = last_bcd;
        frame_dp  = last_dp;
        frame_en  = last_en;
      end
      if (c == 0) slot_on = G + (((int'(bus.brightness) + 1) * (RD - G)) >> 4);
      nib = frame_bcd[4*d +: 4];
      blank = LZB && (d != 0) && ((frame_bcd >> (4*d)) == 16'h0) && !frame_dp[d];
      lit = (c >= G) && (c < slot_on) && frame_en[d] && !blank;
      exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
      exp_seg = lit ? glyph[nib] : 7'h7F;
      exp_dp  = lit ? ~frame_dp[d] : 1'b1;
      exp_ft  = (p == 0);
    end else begin
      k = 0;
      last_bcd = '0; frame_bcd = '0;
      last_dp = '0; frame_dp = '0;
      last_en = '0; frame_en = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] bcd, input logic [3:0] dpv, input logic [3:0] en);
    bus.input_bcd = bcd;
    bus.dp_in     = dpv;
    bus.digit_en  = en;
    bus.load      = 1'b1;
  endtask

  task automatic align();
    while (k % FRAME != 0) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load = 1'b0; bus.input_bcd = '0; bus.dp_in = '0; bus.digit_en = '0; bus.brightness = '0;
    repeat (3) cycle();
    n_total++; if (bus.an !== 4'hF) $display("FAIL reset_an got=%b want=1111", bus.an); else n_pass++;
    n_total++; if (bus.seg !== 7'h7F) $display("FAIL reset_seg got=%h want=7f", bus.seg); else n_pass++;
    n_total++; if (bus.dp !== 1'b1) $display("FAIL reset_dp got=%b want=1", bus.dp); else n_pass++;
    n_total++; if (bus.frame_tick !== 1'b0) $display("FAIL reset_ft got=%b want=0", bus.frame_tick); else n_pass++;
  endtask

  task automatic test_basic();
    logic [6:0] want_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] want_an;
    int lit_cnt = 0;
    bus.brightness = 4'd15;
    drive_load(16'h1234, 4'h0, 4'hF);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      bus.load = 1'b0;
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL basic_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
      if (bus.an != 4'hF) lit_cnt++;
      if (i == 0) begin
        n_total++;
        if (bus.frame_tick !== 1'b1) $display("FAIL basic_first_tick got=%b want=1", bus.frame_tick); else n_pass++;
      end
      if (i % RD == G) begin
        want_an = ~(4'b0001 << (i / RD));
        n_total++;
        if ({bus.an, bus.seg} !== {want_an, want_seg[i / RD]})
          $display("FAIL basic_digit slot=%0d got an=%b seg=%h want an=%b seg=%h",
                   i / RD, bus.an, bus.seg, want_an, want_seg[i / RD]);
        else n_pass++;
      end
      if (i % RD < G) begin
        n_total++;
        if (bus.an !== 4'hF) $display("FAIL basic_guard i=%0d got an=%b want=1111", i, bus.an); else n_pass++;
      end
    end
    n_total++;
    if (lit_cnt != 56) $display("FAIL basic_on_cycles got=%0d want=56", lit_cnt); else n_pass++;
  endtask

  task automatic test_brightness();
    int lit_cnt, bad_cnt;
    int want_lit [2] = '{0, 28};
    logic [3:0] levels [2] = '{4'd0, 4'd7};
    for (int f = 0; f < 2; f++) begin
      align();
      bus.brightness = levels[f];
      lit_cnt = 0;
      bad_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        cycle();
        n_total++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
          $display("FAIL bright_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                   k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
        else n_pass++;
        if (bus.an != 4'hF) begin
          lit_cnt++;
          if ((i % RD < 2) || (i % RD > 8)) bad_cnt++;
        end
      end
      n_total++;
      if (lit_cnt != want_lit[f])
        $display("FAIL bright_on_cycles level=%0d got=%0d want=%0d", levels[f], lit_cnt, want_lit[f]);
      else n_pass++;
      n_total++;
      if (bad_cnt != 0) $display("FAIL bright_window level=%0d got=%0d want=0", levels[f], bad_cnt); else n_pass++;
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] want_d0 [4] = '{7'h19, 7'h21, 7'h78, 7'h78};
    align();
    bus.brightness = 4'd15;
    for (int i = 0; i < 4 * FRAME; i++) begin
      case (i)
        20:  drive_load(16'hABCD, 4'h0, 4'hF);
        74:  drive_load(16'h1111, 4'h0, 4'hF);
        94:  drive_load(16'h2222, 4'h0, 4'hF);
        128: drive_load(16'hE0F7, 4'h0, 4'hF);
        default: ;
      endcase
      cycle();
      bus.load = 1'b0;
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL tear_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
      if (i % FRAME == G) begin
        n_total++;
        if (bus.seg !== want_d0[i / FRAME])
          $display("FAIL tear_digit0 frame=%0d got seg=%h want=%h", i / FRAME, bus.seg, want_d0[i / FRAME]);
        else n_pass++;
      end
      if (i == FRAME + 3 * RD + G) begin
        n_total++;
        if (bus.seg !== 7'h08) $display("FAIL tear_digit3 got seg=%h want=08", bus.seg); else n_pass++;
      end
    end
  endtask

  task automatic test_dp_en();
    int d13_lit = 0, an0_low = 0, dp_low = 0, dp_outside = 0;
    align();
    bus.brightness = 4'd15;
    drive_load(16'h9876, 4'b0001, 4'b0101);
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      bus.load = 1'b0;
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL dpen_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
      if (!bus.an[1] || !bus.an[3]) d13_lit++;
      if (!bus.an[0]) an0_low++;
      if (!bus.dp) dp_low++;
      if (!bus.dp && bus.an[0]) dp_outside++;
    end
    n_total++; if (d13_lit != 0) $display("FAIL dpen_disabled_lit got=%0d want=0", d13_lit); else n_pass++;
    n_total++; if (an0_low != 14) $display("FAIL dpen_digit0_on got=%0d want=14", an0_low); else n_pass++;
    n_total++; if (dp_low != 14) $display("FAIL dpen_dp_low got=%0d want=14", dp_low); else n_pass++;
    n_total++; if (dp_outside != 0) $display("FAIL dpen_dp_outside got=%0d want=0", dp_outside); else n_pass++;
  endtask

  task automatic test_lzb();
    logic [15:0] bcds [3] = '{16'h0005, 16'h0000, 16'h0005};
    logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b0100};
    int want_digits [3];
    logic [3:0] seen;
    int wrong_glyph;
    want_digits[0] = LZB ? 1 : 4;
    want_digits[1] = LZB ? 1 : 4;
    want_digits[2] = LZB ? 2 : 4;
    bus.brightness = 4'd15;
    for (int t = 0; t < 3; t++) begin
      align();
      drive_load(bcds[t], dps[t], 4'hF);
      seen = '0;
      wrong_glyph = 0;
      for (int i = 0; i < FRAME; i++) begin
        cycle();
        bus.load = 1'b0;
        n_total++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
          $display("FAIL lzb_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                   k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
        else n_pass++;
        seen = seen | ~bus.an;
        if (t == 1 && bus.an != 4'hF && bus.seg != 7'h40) wrong_glyph++;
      end
      n_total++;
      if ($countones(seen) != want_digits[t])
        $display("FAIL lzb_digits case=%0d got=%0d want=%0d", t, $countones(seen), want_digits[t]);
      else n_pass++;
      if (t == 1) begin
        n_total++;
        if (wrong_glyph != 0) $display("FAIL lzb_zero_glyph got=%0d want=0", wrong_glyph); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(19) == 0)
        drive_load(16'($urandom) & masks[$urandom_range(3)], 4'($urandom), 4'($urandom));
      if ($urandom_range(31) == 0) bus.brightness = 4'($urandom);
      cycle();
      bus.load = 1'b0;
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL rand_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
    end
  endtask

  task automatic test_midreset();
    int lit_cnt = 0;
    align();
    bus.brightness = 4'd15;
    drive_load(16'h1234, 4'h0, 4'hF);
    for (int i = 0; i < 2 * RD + 8; i++) begin
      cycle();
      bus.load = 1'b0;
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL mrst_pre_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
    end
    n_total++;
    if (bus.an !== 4'b1011) $display("FAIL mrst_lit_before got an=%b want=1011", bus.an); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL mrst_blank got an=%b seg=%h dp=%b ft=%b want an=1111 seg=7f dp=1 ft=0",
               bus.an, bus.seg, bus.dp, bus.frame_tick);
    else n_pass++;
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL mrst_post_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
      if (bus.an != 4'hF) lit_cnt++;
      if (i == 0) begin
        n_total++;
        if (bus.frame_tick !== 1'b1) $display("FAIL mrst_first_tick got=%b want=1", bus.frame_tick); else n_pass++;
      end
    end
    n_total++;
    if (lit_cnt != 0) $display("FAIL mrst_cleared_display got=%0d want=0", lit_cnt); else n_pass++;
    drive_load(16'h1234, 4'h0, 4'hF);
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      bus.load = 1'b0;
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft})
        $display("FAIL mrst_reload_model k=%0d got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 k, bus.an, bus.seg, bus.dp, bus.frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      else n_pass++;
      if (i == G) begin
        n_total++;
        if (bus.seg !== 7'h19) $display("FAIL mrst_reload_digit0 got seg=%h want=19", bus.seg); else n_pass++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "timeout");
  end

  initial begin
    k = 0;
    slot_on = 0;
    test_reset();
    test_basic();
    test_brightness();
    test_tear_free();
    test_dp_en();
    test_lzb();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
